// File: rtl/adder_pipeline_pkg.sv
// Shared constants, lane result type and the lane adder for adder_pipeline.
// Defining ADDER_PIPELINE_SATURATE_EN makes overflowing lanes saturate instead of wrap.
package adder_pipeline_pkg;

  localparam int unsigned DefaultWidth    = 32;
  localparam int unsigned DefaultChannels = 1;
  localparam int unsigned DefaultStages   = 2;

  // Widest lane the shared adder handles; narrower lanes live in the low bits.
  localparam int unsigned MaxWidth = 64;

  typedef struct packed {
    logic                carry;
    logic [MaxWidth-1:0] sum;
  } lane_t;

  // Operands must be zero above bit width-1.
  function automatic lane_t add_lane(input logic [MaxWidth-1:0] a,
                                     input logic [MaxWidth-1:0] b,
                                     input int unsigned         width);
    logic [MaxWidth:0]   full;
    logic [MaxWidth-1:0] mask;
    lane_t               res;
    full      = {1'b0, a} + {1'b0, b};
    mask      = ~({MaxWidth{1'b1}} << width);
    res.carry = (full >> width) != '0;
`ifdef ADDER_PIPELINE_SATURATE_EN
    res.sum   = res.carry ? mask : (full[MaxWidth-1:0] & mask);
`else
    res.sum   = full[MaxWidth-1:0] & mask;
`endif
    return res;
  endfunction

endpackage

// File: rtl/adder_pipeline_stage.sv
// One elastic register stage: loads when told to, otherwise holds valid and data.
module adder_pipeline_stage #(
  parameter int unsigned DataWidth = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 in_valid,
  input  logic [DataWidth-1:0] in_data,
  output logic                 valid,
  output logic [DataWidth-1:0] data
);

  logic                 valid_q;
  logic [DataWidth-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= in_valid;
      // Bubbles leave the data register untouched so the output holds its last value.
      if (in_valid) begin
        data_q <= in_data;
      end
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/adder_pipeline.sv
// Multi-lane pipelined adder with valid/ready on both sides and per-lane carry-out.
// ADDER_PIPELINE_SATURATE_EN (see package) selects saturating lane sums.
module adder_pipeline
  import adder_pipeline_pkg::*;
#(
  parameter int unsigned WIDTH    = DefaultWidth,
  parameter int unsigned CHANNELS = DefaultChannels,
  parameter int unsigned STAGES   = DefaultStages
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [CHANNELS*WIDTH-1:0] i_a,
  input  logic [CHANNELS*WIDTH-1:0] i_b,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [CHANNELS*WIDTH-1:0] o_a,
  output logic [CHANNELS-1:0]       o_carry,
  output logic                      o_busy
);

  localparam int unsigned DataW = CHANNELS * WIDTH + CHANNELS;

  // Index 0 is the input side; index s+1 is the output of stage s.
  logic [STAGES:0]            valid;
  logic [STAGES:0]            ready;
  logic [STAGES:0][DataW-1:0] data;

  logic [CHANNELS*WIDTH-1:0] sum0;
  logic [CHANNELS-1:0]       carry0;
  logic [MaxWidth-1:0]       a_ext;
  logic [MaxWidth-1:0]       b_ext;
  lane_t                     res;
  logic                      unused_hi;

  always_comb begin
    sum0      = '0;
    carry0    = '0;
    a_ext     = '0;
    b_ext     = '0;
    res       = '0;
    unused_hi = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      a_ext              = '0;
      b_ext              = '0;
      a_ext[WIDTH-1:0]   = i_a[k*WIDTH +: WIDTH];
      b_ext[WIDTH-1:0]   = i_b[k*WIDTH +: WIDTH];
      res                = add_lane(a_ext, b_ext, WIDTH);
      sum0[k*WIDTH +: WIDTH] = res.sum[WIDTH-1:0];
      carry0[k]          = res.carry;
      unused_hi          = unused_hi ^ (^(res.sum >> WIDTH));
    end
  end

  // A stage may load when empty or when the stage after it moves on this cycle.
  always_comb begin
    ready         = '0;
    ready[STAGES] = i_ready;
    for (int unsigned s = 0; s < STAGES; s++) begin
      ready[STAGES-1-s] = !valid[STAGES-s] || ready[STAGES-s];
    end
  end

  assign valid[0] = i_valid;
  assign data[0]  = {carry0, sum0};

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    adder_pipeline_stage #(
      .DataWidth(DataW)
    ) u_stage (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .load    (ready[s]),
      .in_valid(valid[s]),
      .in_data (data[s]),
      .valid   (valid[s+1]),
      .data    (data[s+1])
    );
  end

  assign o_ready          = i_rst_n && ready[0];
  assign o_valid          = valid[STAGES];
  assign {o_carry, o_a}   = data[STAGES];
  assign o_busy           = |valid[STAGES:1];

endmodule

// File: tb/tb_adder_pipeline.sv
// Randomised and directed bench for adder_pipeline with a queue-based reference model.
module tb_adder_pipeline;

  localparam int unsigned W = 8;
  localparam int unsigned C = 2;
  localparam int unsigned S = 2;
`ifdef ADDER_PIPELINE_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           i_valid, i_ready, o_ready, o_valid, o_busy;
  logic [C*W-1:0] i_a, i_b, o_a;
  logic [C-1:0]   o_carry;

  logic       s_valid, s_ready, s_oready, s_ovalid, s_busy;
  logic [0:0] s_a, s_b, s_o, s_carry;

  int n_vec = 0;
  int n_err = 0;
  int n_del = 0;
  int n_acc = 0;
  int base;
  logic [C*W-1:0] held;
  logic [C*W+C-1:0] exp_q[$];

  adder_pipeline #(.WIDTH(W), .CHANNELS(C), .STAGES(S)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_a(i_a), .i_b(i_b),
    .o_valid(o_valid), .i_ready(i_ready), .o_a(o_a), .o_carry(o_carry), .o_busy(o_busy)
  );

  adder_pipeline #(.WIDTH(1), .CHANNELS(1), .STAGES(1)) u_dut_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(s_valid), .o_ready(s_oready), .i_a(s_a), .i_b(s_b),
    .o_valid(s_ovalid), .i_ready(s_ready), .o_a(s_o), .o_carry(s_carry), .o_busy(s_busy)
  );

  // Expected {carries, sums} from plain per-lane integer addition.
  function automatic logic [C*W+C-1:0] model(input logic [C*W-1:0] a, input logic [C*W-1:0] b);
    logic [C*W-1:0] sum;
    logic [C-1:0]   cy;
    int unsigned    x, y, t;
    for (int k = 0; k < C; k++) begin
      x = 32'(a[k*W +: W]);
      y = 32'(b[k*W +: W]);
      t = x + y;
      cy[k] = (t >= (32'd1 << W));
      sum[k*W +: W] = (Sat && cy[k]) ? {W{1'b1}} : W'(t % (32'd1 << W));
    end
    return {cy, sum};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples handshakes just after the negedge, scores deliveries, then advances one clock.
  task automatic cycle();
    logic acc, del;
    logic [C*W+C-1:0] e;
    #1;
    acc = i_valid && o_ready;
    del = o_valid && i_ready;
    if (del) begin
      check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat_data", 64'({o_carry, o_a}), 64'(e));
      end
      n_del++;
    end
    if (acc) begin
      exp_q.push_back(model(i_a, i_b));
      n_acc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    i_valid = 1'b0; i_ready = 1'b1; i_a = '0; i_b = '0;
    s_valid = 1'b0; s_ready = 1'b1; s_a = '0; s_b = '0;

    // Reset state
    @(negedge clk);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_a", 64'(o_a), 64'd0);
    check("rst_carry", 64'(o_carry), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_ready_low", 64'(o_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_ready_high", 64'(o_ready), 64'd1);
    @(negedge clk);

    // Directed lane example: 3+4 and 200+100
    i_a = {8'd200, 8'd3}; i_b = {8'd100, 8'd4}; i_valid = 1'b1;
    cycle();
    i_valid = 1'b0;
    check("lat_not_yet", 64'(o_valid), 64'd0);
    cycle();
    check("lat_valid", 64'(o_valid), 64'd1);
    check("ex_sum", 64'(o_a), 64'({(Sat ? 8'd255 : 8'd44), 8'd7}));
    check("ex_carry", 64'(o_carry), 64'(2'b10));
    check("ex_busy", 64'(o_busy), 64'd1);
    cycle();
    check("drained_valid", 64'(o_valid), 64'd0);
    check("drained_busy", 64'(o_busy), 64'd0);

    // Back-to-back random stream
    base = n_del;
    for (int i = 0; i < 16; i++) begin
      i_valid = 1'b1;
      i_a = 16'($urandom);
      i_b = 16'($urandom);
      if (i >= 2) begin
        check("stream_ready", 64'(o_ready), 64'd1);
        check("stream_valid", 64'(o_valid), 64'd1);
      end
      cycle();
    end
    i_valid = 1'b0;
    repeat (3) cycle();
    check("stream_count", 64'(n_del - base), 64'd16);

    // Backpressure: three beats offered with i_ready low
    base = n_acc;
    i_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      i_valid = 1'b1;
      i_a = 16'($urandom);
      i_b = 16'($urandom);
      if (j == 2) begin
        #1;
        check("full_ready_low", 64'(o_ready), 64'd0);
        held = o_a;
      end
      cycle();
    end
    check("stall_accepts", 64'(n_acc - base), 64'd2);
    check("stall_a_stable", 64'(o_a), 64'(held));
    check("stall_valid", 64'(o_valid), 64'd1);

    // Full pipeline: accept and drain in the same cycle
    i_ready = 1'b1;
    #1;
    check("full_accept_drain", 64'(o_ready), 64'd1);
    base = n_acc;
    cycle();
    check("full_accepted", 64'(n_acc - base), 64'd1);
    i_valid = 1'b0;
    repeat (3) cycle();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset with two beats in flight
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_a = {8'd5, 8'd6}; i_b = {8'd7, 8'd9};
    cycle();
    cycle();
    i_valid = 1'b0;
    check("pre_rst_busy", 64'(o_busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(o_valid), 64'd0);
    check("mid_rst_a", 64'(o_a), 64'd0);
    check("mid_rst_carry", 64'(o_carry), 64'd0);
    check("mid_rst_busy", 64'(o_busy), 64'd0);
    check("mid_rst_ready", 64'(o_ready), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    base = n_del;
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_a = 16'($urandom);
    i_b = 16'($urandom);
    cycle();
    i_valid = 1'b0;
    repeat (4) cycle();
    check("post_rst_count", 64'(n_del - base), 64'd1);

    // Single-stage, one-bit instance: 1+1
    s_a = 1'b1; s_b = 1'b1; s_valid = 1'b1;
    #1;
    check("small_ready", 64'(s_oready), 64'd1);
    check("small_idle", 64'(s_ovalid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    check("small_valid", 64'(s_ovalid), 64'd1);
    check("small_sum", 64'(s_o), 64'(Sat ? 1'b1 : 1'b0));
    check("small_carry", 64'(s_carry), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("small_drained", 64'(s_busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
